// File: rtl/serial_adder.sv
// Bit-serial adder: shifts two WIDTH-bit operands through a one-bit full adder,
// LSB first, and publishes the registered sum and carry-out when all bits are consumed.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_full;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit;
  logic             carry_nxt;
  logic             last_bit;

  assign s_bit     = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit  = (cnt == LAST_BIT);

  // Sum register with the current bit shifted in, i.e. the complete result on the last RUN cycle.
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_full = s_bit;
    end else begin : g_wn
      assign s_full = {s_bit, s_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath; sum/cout only change on the RUN->DONE edge so they hold across the next addition.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_full;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= s_full;
            cout <= carry_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): scoreboard of expected {cout,sum}
// pushed at stimulus time and popped whenever the DUT pulses done.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;

  int         checks = 0;
  int         errors = 0;
  int         cycle  = 0;
  logic [8:0] sb[$];
  logic [8:0] mon_exp;
  logic [8:0] last_res;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .sum  (sum),
    .cout (cout),
    .busy (busy),
    .done (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Any done pulse must match the oldest outstanding request; an empty queue means a spurious done.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 1, 0);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("result", {23'd0, cout, sum}, {23'd0, mon_exp});
      end
    end
  end

  // Issues one single-cycle start from IDLE, scrambles a/b after acceptance, and checks timing.
  task automatic applyStimulus(input logic [7:0] a_v, input logic [7:0] b_v);
    logic [8:0] exp;
    int         n;
    int         nb;
    bit         seen;
    exp = {1'b0, a_v} + {1'b0, b_v};
    @(posedge clk); #1;
    a = a_v; b = b_v; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    n = 0; nb = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) checkOutput("hold_prev_result", {23'd0, cout, sum}, {23'd0, last_res});
      if (busy) nb++;
      if (done) seen = 1;
    end
    checkOutput("latency", n, 9);
    checkOutput("busy_cycles", nb, 8);
    last_res = exp;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int         n;
    int         k;
    int         t[3];
    bit         seen;
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF;
    last_res = 9'd0;

    // Reset with start asserted: nothing must launch.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("rst_start_discarded", busy, 0);

    applyStimulus(8'h0F, 8'h01);
    applyStimulus(8'hFF, 8'h01);
    applyStimulus(8'hFF, 8'hFF);
    applyStimulus(8'h00, 8'h00);

    // Second start during RUN must be dropped.
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; start = 1'b1;
    sb.push_back(9'h046);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk); #1;
    a = 8'h55; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    checkOutput("repulse_done_seen", seen, 1);
    repeat (15) @(negedge clk);
    checkOutput("repulse_idle", busy, 0);
    last_res = 9'h046;

    // Reset mid-RUN: aborted addition leaves zeroed outputs and no done.
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_sum", sum, 0);
    checkOutput("abort_cout", cout, 0);
    repeat (15) @(negedge clk);
    last_res = 9'd0;
    applyStimulus(8'h03, 8'h04);

    // Start held high: back-to-back additions with a/b scrambled while busy.
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80; start = 1'b1;
    repeat (3) sb.push_back(9'h100);
    k = 0; n = 0;
    while (k < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (done) begin
        t[k] = cycle;
        k++;
        if (k == 3) start = 1'b0;
        a = 8'h80; b = 8'h80;
      end else if (busy) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end else begin
        a = 8'h80; b = 8'h80;
      end
    end
    checkOutput("held_done_count", k, 3);
    if (k == 3) begin
      checkOutput("held_period_1", t[1] - t[0], 10);
      checkOutput("held_period_2", t[2] - t[1], 10);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
